// File: rtl/ternary_program_counter_stack_pkg.sv
// Shared definitions for the balanced-ternary program counter.
//
// Trit encoding (2 bits per trit, trit i at bits [2i+1:2i]):
//    2'b10 = -1, 2'b00 = 0, 2'b01 = +1; 2'b11 is unused and reads as 0.
// Also provides the pc_op codes and trit <-> integer helpers.
package ternary_program_counter_stack_pkg;

   localparam logic [1:0] TRIT_NEG  = 2'b10;
   localparam logic [1:0] TRIT_ZERO = 2'b00;
   localparam logic [1:0] TRIT_POS  = 2'b01;

   typedef enum logic [2:0] {
      PC_OP_HOLD     = 3'd0,
      PC_OP_INC      = 3'd1,
      PC_OP_REL      = 3'd2,
      PC_OP_ABS      = 3'd3,
      PC_OP_CALL_REL = 3'd4,
      PC_OP_CALL_ABS = 3'd5,
      PC_OP_RET      = 3'd6,
      PC_OP_RSVD     = 3'd7
   } pc_op_e;

   function automatic int trit_val(input logic [1:0] t);
      case (t)
         TRIT_POS: return 1;
         TRIT_NEG: return -1;
         default:  return 0;
      endcase
   endfunction

   function automatic logic [1:0] trit_enc(input int v);
      if (v > 0)      return TRIT_POS;
      else if (v < 0) return TRIT_NEG;
      else            return TRIT_ZERO;
   endfunction

endpackage

// File: rtl/ternary_addr_adder.sv
// Combinational balanced-ternary adder.
//
// Ports:
//    a, b   in   2*TRITS  addends
//    sum    out  2*TRITS  a + b modulo 3^TRITS (symmetric range)
//    carry  out  2        trit carried out of the top position
module ternary_addr_adder
   import ternary_program_counter_stack_pkg::*;
#(
   parameter int unsigned TRITS = 9
) (
   input  logic [2*TRITS-1:0] a,
   input  logic [2*TRITS-1:0] b,
   output logic [2*TRITS-1:0] sum,
   output logic [1:0]         carry
);

   always_comb begin
      int c;
      int d;
      sum = '0;
      c   = 0;
      d   = 0;
      // Digit sum ranges -3..+3; fold back into one trit plus a carry.
      for (int unsigned i = 0; i < TRITS; i++) begin
         d = trit_val(a[2*i +: 2]) + trit_val(b[2*i +: 2]) + c;
         if (d > 1) begin
            d = d - 3;
            c = 1;
         end else if (d < -1) begin
            d = d + 3;
            c = -1;
         end else begin
            c = 0;
         end
         sum[2*i +: 2] = trit_enc(d);
      end
      carry = trit_enc(c);
   end

endmodule

// File: rtl/ternary_program_counter_stack.sv
// Balanced-ternary program counter with return-address stack (RAS).
//
// Ports:
//    clock            in   system clock, rising edge
//    reset_enable_n   in   synchronous active-low reset
//    update_enable    in   0 freezes all state
//    pc_op            in   3-bit operation (HOLD/INC/REL/ABS/CALL_REL/CALL_ABS/RET)
//    operand          in   2*OPND_TRITS offset or target
//    pc_out           out  2*ADDR_TRITS current program counter
//    stack_empty      out  RAS holds no entries
//    stack_full       out  RAS holds STACK_DEPTH entries
//    stack_overflow   out  sticky: CALL while full
//    stack_underflow  out  sticky: RET while empty
//    pc_wrap          out  only with TPC_WRAP_FLAG_EN defined: one-cycle flag after
//                          an INC/REL/CALL_REL that wrapped or dropped operand trits
module ternary_program_counter_stack
   import ternary_program_counter_stack_pkg::*;
#(
   parameter int unsigned              ADDR_TRITS  = 9,
   parameter int unsigned              OPND_TRITS  = 9,
   parameter int unsigned              STACK_DEPTH = 4,
   parameter logic [2*ADDR_TRITS-1:0] RESET_ADDR  = '0
) (
   input  logic                    clock,
   input  logic                    reset_enable_n,
   input  logic                    update_enable,
   input  logic [2:0]              pc_op,
   input  logic [2*OPND_TRITS-1:0] operand,
   output logic [2*ADDR_TRITS-1:0] pc_out,
   output logic                    stack_empty,
   output logic                    stack_full,
   output logic                    stack_overflow,
   output logic                    stack_underflow
`ifdef TPC_WRAP_FLAG_EN
   ,
   output logic                    pc_wrap
`endif
);

   localparam int unsigned PW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [2*ADDR_TRITS-1:0] ONE = (2*ADDR_TRITS)'(TRIT_POS);

   pc_op_e                  op;
   logic [2*ADDR_TRITS-1:0] ras [STACK_DEPTH];
   logic [PW-1:0]           ptr;
   logic [IW-1:0]           push_idx;
   logic [IW-1:0]           pop_idx;
   logic [2*ADDR_TRITS-1:0] abs_target;
   logic [2*ADDR_TRITS-1:0] rel_sum;
   logic [2*ADDR_TRITS-1:0] inc_sum;
   logic [1:0]              rel_carry;
   logic [1:0]              inc_carry;
   logic                    op_hi_nz;

   assign op         = pc_op_e'(pc_op);
   assign abs_target = operand[2*ADDR_TRITS-1:0];
   assign push_idx   = IW'(ptr);
   assign pop_idx    = IW'(ptr - PW'(1));

   assign stack_empty = (ptr == '0);
   assign stack_full  = (ptr == PW'(STACK_DEPTH));

   ternary_addr_adder #(.TRITS(ADDR_TRITS)) u_rel_adder (
      .a     (pc_out),
      .b     (abs_target),
      .sum   (rel_sum),
      .carry (rel_carry)
   );

   ternary_addr_adder #(.TRITS(ADDR_TRITS)) u_inc_adder (
      .a     (pc_out),
      .b     (ONE),
      .sum   (inc_sum),
      .carry (inc_carry)
   );

   // Operand trits above the address width that truncation drops.
   generate
      if (OPND_TRITS > ADDR_TRITS) begin : g_op_hi
         assign op_hi_nz = |operand[2*OPND_TRITS-1:2*ADDR_TRITS];
      end else begin : g_no_op_hi
         assign op_hi_nz = 1'b0;
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (!reset_enable_n) begin
         pc_out          <= RESET_ADDR;
         ptr             <= '0;
         stack_overflow  <= 1'b0;
         stack_underflow <= 1'b0;
      end else if (update_enable) begin
         case (op)
            PC_OP_INC: pc_out <= inc_sum;
            PC_OP_REL: pc_out <= rel_sum;
            PC_OP_ABS: pc_out <= abs_target;
            PC_OP_CALL_REL, PC_OP_CALL_ABS: begin
               if (stack_full) begin
                  stack_overflow <= 1'b1;
               end else begin
                  ras[push_idx] <= inc_sum;
                  ptr           <= ptr + PW'(1);
                  pc_out        <= (op == PC_OP_CALL_REL) ? rel_sum : abs_target;
               end
            end
            PC_OP_RET: begin
               if (stack_empty) begin
                  stack_underflow <= 1'b1;
               end else begin
                  pc_out <= ras[pop_idx];
                  ptr    <= ptr - PW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef TPC_WRAP_FLAG_EN
   always_ff @(posedge clock) begin
      if (!reset_enable_n) begin
         pc_wrap <= 1'b0;
      end else begin
         pc_wrap <= 1'b0;
         if (update_enable) begin
            case (op)
               PC_OP_INC:      pc_wrap <= (inc_carry != TRIT_ZERO);
               PC_OP_REL:      pc_wrap <= (rel_carry != TRIT_ZERO) || op_hi_nz;
               PC_OP_CALL_REL: pc_wrap <= !stack_full && ((rel_carry != TRIT_ZERO) || op_hi_nz);
               default: ;
            endcase
         end
      end
   end
`else
   logic unused_wrap_inputs;
   assign unused_wrap_inputs = ^{op_hi_nz, rel_carry, inc_carry};
`endif

endmodule

// File: tb/tb_ternary_program_counter_stack.sv
// Self-checking bench: directed steps then random operations, compared against
// an integer/queue model of the program counter and return-address stack.
module tb_ternary_program_counter_stack;

   localparam int AT    = 4;
   localparam int OT    = 6;
   localparam int DEPTH = 2;
   localparam int HALF  = 40;   // (3^AT - 1) / 2
   localparam int MOD   = 81;   // 3^AT
   localparam int OHALF = 364;  // (3^OT - 1) / 2

   localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, REL = 3'd2, ABS = 3'd3,
                          CREL = 3'd4, CABS = 3'd5, RET = 3'd6, RSVD = 3'd7;

   logic            clock = 1'b0;
   logic            reset_enable_n = 1'b1;
   logic            update_enable = 1'b0;
   logic [2:0]      pc_op = 3'd0;
   logic [2*OT-1:0] operand = '0;
   logic [2*AT-1:0] pc_out;
   logic            stack_empty, stack_full, stack_overflow, stack_underflow;
`ifdef TPC_WRAP_FLAG_EN
   logic            pc_wrap;
`endif

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_pc;
   int m_stack[$];
   bit m_ovf, m_unf, m_wrap;

   ternary_program_counter_stack #(
      .ADDR_TRITS  (AT),
      .OPND_TRITS  (OT),
      .STACK_DEPTH (DEPTH),
      .RESET_ADDR  ('0)
   ) dut (
      .clock           (clock),
      .reset_enable_n  (reset_enable_n),
      .update_enable   (update_enable),
      .pc_op           (pc_op),
      .operand         (operand),
      .pc_out          (pc_out),
      .stack_empty     (stack_empty),
      .stack_full      (stack_full),
      .stack_overflow  (stack_overflow),
      .stack_underflow (stack_underflow)
`ifdef TPC_WRAP_FLAG_EN
      ,
      .pc_wrap         (pc_wrap)
`endif
   );

   always #5 clock = ~clock;

   function automatic int wrapv(input int v);
      return (((v + HALF) % MOD) + MOD) % MOD - HALF;
   endfunction

   function automatic logic [2*OT-1:0] enc_op(input int v);
      logic [2*OT-1:0] r;
      int x, rem;
      r = '0;
      x = v;
      for (int i = 0; i < OT; i++) begin
         rem = ((x % 3) + 3) % 3;
         if (rem == 1) begin
            r[2*i +: 2] = 2'b01; x = (x - 1) / 3;
         end else if (rem == 2) begin
            r[2*i +: 2] = 2'b10; x = (x + 1) / 3;
         end else begin
            x = x / 3;
         end
      end
      return r;
   endfunction

   function automatic logic [2*AT-1:0] enc_pc(input int v);
      logic [2*OT-1:0] w;
      w = enc_op(v);
      return w[2*AT-1:0];
   endfunction

   task automatic chk(input string tag, input logic [2*AT-1:0] got, input logic [2*AT-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("pc_out", pc_out, enc_pc(m_pc));
      chk("stack_empty", 8'(stack_empty), 8'(m_stack.size() == 0));
      chk("stack_full", 8'(stack_full), 8'(m_stack.size() == DEPTH));
      chk("stack_overflow", 8'(stack_overflow), 8'(m_ovf));
      chk("stack_underflow", 8'(stack_underflow), 8'(m_unf));
`ifdef TPC_WRAP_FLAG_EN
      chk("pc_wrap", 8'(pc_wrap), 8'(m_wrap));
`endif
   endtask

   task automatic step(input bit rst, input bit en, input logic [2:0] op, input int opnd);
      int low, raw;
      @(negedge clock);
      reset_enable_n = !rst;
      update_enable  = en;
      pc_op          = op;
      operand        = enc_op(opnd);
      @(posedge clock);
      #1;
      low = wrapv(opnd);
      if (rst) begin
         m_pc = 0;
         m_stack.delete();
         m_ovf = 0; m_unf = 0; m_wrap = 0;
      end else begin
         m_wrap = 0;
         if (en) begin
            case (op)
               INC: begin
                  raw = m_pc + 1;
                  m_wrap = (raw != wrapv(raw));
                  m_pc = wrapv(raw);
               end
               REL: begin
                  raw = m_pc + low;
                  m_wrap = (raw != wrapv(raw)) || (opnd != low);
                  m_pc = wrapv(raw);
               end
               ABS: m_pc = low;
               CREL, CABS: begin
                  if (m_stack.size() == DEPTH) m_ovf = 1;
                  else begin
                     m_stack.push_back(wrapv(m_pc + 1));
                     if (op == CREL) begin
                        raw = m_pc + low;
                        m_wrap = (raw != wrapv(raw)) || (opnd != low);
                        m_pc = wrapv(raw);
                     end else begin
                        m_pc = low;
                     end
                  end
               end
               RET: begin
                  if (m_stack.size() == 0) m_unf = 1;
                  else m_pc = m_stack.pop_back();
               end
               default: ;
            endcase
         end
      end
      check_all();
   endtask

   initial begin
      // reset then INC x3
      step(1, 0, HOLD, 0);
      step(0, 1, INC, 0);
      step(0, 1, INC, 0);
      step(0, 1, INC, 0);
      // REL / ABS / disabled update
      step(0, 1, ABS, 5);
      step(0, 1, REL, -7);
      step(0, 1, ABS, 13);
      step(0, 0, INC, 0);
      step(0, 1, RSVD, 20);
      // call / return
      step(0, 1, ABS, 10);
      step(0, 1, CABS, 30);
      step(0, 1, RET, 0);
      // overflow then underflow
      step(1, 1, RET, 0);
      step(0, 1, CREL, 1);
      step(0, 1, CREL, 1);
      step(0, 1, CREL, 1);
      step(0, 1, RET, 0);
      step(0, 1, RET, 0);
      step(0, 1, RET, 0);
      // wrap at the top of the range, and dropped operand trits
      step(0, 1, ABS, 40);
      step(0, 1, INC, 0);
      step(0, 1, HOLD, 0);
      step(0, 1, ABS, -40);
      step(0, 1, REL, -1);
      step(0, 1, REL, 81 + 2);
      step(0, 1, ABS, 81 + 7);
      // reset with stack non-empty and flags set
      step(0, 1, CABS, 5);
      step(0, 1, CABS, 6);
      step(0, 1, CABS, 7);
      step(1, 1, CABS, 9);
      step(0, 1, RET, 0);
      // random traffic
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0,
              3'($urandom_range(0, 7)), int'($urandom_range(0, 2*OHALF)) - OHALF);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ternary_program_counter_stack.md
Name: ternary_program_counter_stack

Overview:
- Next-generation balanced-ternary program counter for the ternary CPU core.
- Parametrised address width.
- Adds increment, relative branch, absolute jump, call and return.
- Call and return use an internal return-address stack (RAS) with sticky overflow/underflow error flags.
- Sits between the instruction decoder (drives pc_op/operand) and instruction memory (consumes pc_out).

Parameters:
- ADDR_TRITS, 9, trits in the program counter and each RAS entry.
- OPND_TRITS, 9, trits in the operand input (word size); must be >= ADDR_TRITS.
- STACK_DEPTH, 4, number of RAS entries; must be >= 1.
- RESET_ADDR, all trits `_0, program counter value after reset (2*ADDR_TRITS bits).

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset_enable_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- update_enable  in  1  when 0, all state holds regardless of pc_op.
- pc_op  in  3  0 HOLD, 1 INC, 2 REL, 3 ABS, 4 CALL_REL, 5 CALL_ABS, 6 RET, 7 reserved (treated as HOLD).
- operand  in  2*OPND_TRITS  balanced-ternary offset (REL/CALL_REL) or target (ABS/CALL_ABS).
- pc_out  out  2*ADDR_TRITS  current program counter.
- stack_empty  out  1  RAS holds 0 entries.
- stack_full  out  1  RAS holds STACK_DEPTH entries.
- stack_overflow  out  1  sticky: CALL attempted while full.
- stack_underflow  out  1  sticky: RET attempted while empty.

Behaviour:
- Trit encoding uses the parameters.vh macros: `_1 = -1, `_0 = 0, `_1_ = +1. Trit i occupies bits [2i+1:2i].
- Reset (reset_enable_n = 0 at a clock edge):
  - pc_out = RESET_ADDR.
  - RAS pointer = 0; stack_empty = 1; stack_full = 0.
  - Both sticky flags = 0.
  - Reset overrides update_enable and pc_op, including mid-call.
- Latency: every operation takes effect at the edge where it is sampled; pc_out shows the new value the next cycle. No multi-cycle states.
- HOLD, reserved op, or update_enable = 0: nothing changes.
- INC: pc <= pc + 1.
- REL: pc <= pc + operand, truncated to ADDR_TRITS.
- ABS: pc <= operand[2*ADDR_TRITS-1:0]; upper trits are ignored.
- CALL_REL / CALL_ABS when not full:
  - Push (pc + 1) into the RAS.
  - pc takes the REL/ABS result in the same cycle; pointer increments.
- CALL when full: stack_overflow <= 1; pc and RAS unchanged (call rejected).
- RET when not empty: pc <= top entry; pointer decrements.
- RET when empty: stack_underflow <= 1; pc unchanged.
- Arithmetic: balanced-ternary addition on ADDR_TRITS trits. Carry out of the top trit is discarded (modular wrap).
  - With ADDR_TRITS = 4 the range is -40..+40; +40 + 1 wraps to -40.
  - The operand is sign-correctly truncated to its low ADDR_TRITS trits before addition.
- Sticky flags clear only on reset.
- stack_empty / stack_full are combinational decodes of the pointer.

Optional Feature:
- Macro: TPC_WRAP_FLAG_EN.
- Defined:
  - Adds output pc_wrap (1 bit), registered.
  - pc_wrap = 1 for one cycle after any INC/REL/CALL_REL update whose top-trit carry was non-zero, or whose discarded operand trits were non-zero.
  - pc_wrap resets to 0.
- Undefined: no port, and no logic is generated for this flag.

Decomposition:
- Shared package/header (existing parameters.vh):
  - trit macros;
  - pc_op localparam codes (PC_OP_HOLD ... PC_OP_RET);
  - RESET_ADDR default constant.
- One sub-module: ternary_addr_adder.
  - Combinational, parametrised by TRITS.
  - Inputs: a, b. Outputs: sum and carry trit.
  - Instantiated twice: pc + operand and pc + 1.
- RAS array, pointer and flag logic stay inline.

Test Plan:
- Reset then INC ×3 with ADDR_TRITS = 4 -> pc_out reads 0, 1, 2, 3; stack_empty = 1.
- pc = 5, REL operand = -7 -> pc = -2. Then ABS operand = 13 -> pc = 13. update_enable = 0 with INC -> pc stays 13.
- pc = 10, CALL_ABS 30 -> pc = 30 and RAS top = 11. Then RET -> pc = 11, stack_empty = 1.
- STACK_DEPTH = 2: three CALL_REL +1 from pc = 0:
  - pc = 1, then 2;
  - third call rejected: pc stays 2, stack_overflow = 1, stack_full = 1.
  - Then RET ×3 -> pc 2, 1, then underflow = 1 with pc still 1.
- pc = 40 (ADDR_TRITS = 4), INC -> pc = -40. With TPC_WRAP_FLAG_EN, pc_wrap = 1 for exactly one cycle.
- Mid-sequence reset with stack non-empty and flags set -> next cycle pc = RESET_ADDR, stack_empty = 1, both flags 0. A RET then sets stack_underflow.
